ext_int_responder: RTL and testbench

- Models the external interrupt source that drives the CPU top-level `interrupt` input (HWInt[2]).
- Queues interrupt requests, raises `interrupt`, and holds it until the CPU's handler acknowledges.
- Acknowledge = the CPU top's interrupt-acknowledge write: `m_int_addr` = 0x0000_7f20 with nonzero `m_int_byteen`.
- Intended for the system testbench and the FPGA wrapper, as the partner of the CPU's `m_int_addr`/`m_int_byteen` outputs.

---
 rtl/ext_int_responder.sv | 207 ++++++++++++++++++++
 tb/tb_ext_int_responder.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_int_responder.sv
// ext_int_responder: external interrupt source partnering the CPU's
// m_int_addr/m_int_byteen acknowledge outputs. Queues requests (external
// strobe plus optional periodic auto-request), raises `interrupt`, holds it
// until the handler acknowledges, then enforces a minimum low gap.
// Optional feature macro: EXT_INT_TIMEOUT_EN adds a RAISE watchdog
// (parameter TIMEOUT, sticky output `timeout`).
module ext_int_responder #(
    parameter int unsigned PERIOD   = 0,
    parameter int unsigned MAX_PEND = 7,
    parameter int unsigned GAP_CYC  = 2,
    parameter logic [31:0] ACK_ADDR = 32'h0000_7f20
`ifdef EXT_INT_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT  = 1000
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic [31:0] m_int_addr,
    input  logic [3:0]  m_int_byteen,
    output logic        interrupt,
    output logic [7:0]  pending,
    output logic [15:0] ack_cnt,
    output logic        overflow,
    output logic        spurious
`ifdef EXT_INT_TIMEOUT_EN
    ,
    output logic        timeout
`endif
);

    localparam int unsigned GCNT_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned SUM_W  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAISE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [GCNT_W-1:0]   gcnt;
    logic [GCNT_W-1:0]   gcnt_next;
    logic                auto_req_c;
    logic                ack_c;
    logic                accept_c;
    logic [SUM_W-1:0]    pend_sum_c;
    logic                pend_over_c;
    logic [7:0]          pending_next;
    logic                gap_enter_c;

    // Acknowledge decode: the CPU's interrupt-acknowledge write.
    assign ack_c    = (|m_int_byteen) && (m_int_addr == ACK_ADDR);
    assign accept_c = ack_c && (state == RAISE);

    // Periodic auto-request generator; absent when PERIOD is 0.
    generate
        if (PERIOD > 0) begin : g_period
            localparam int unsigned PCNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
            logic [PCNT_W-1:0] pcnt;

            // Free-running period counter, wraps at PERIOD-1.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pcnt <= '0;
                end else if (pcnt == PCNT_W'(PERIOD - 1)) begin
                    pcnt <= '0;
                end else begin
                    pcnt <= pcnt + PCNT_W'(1);
                end
            end

            assign auto_req_c = (pcnt == PCNT_W'(PERIOD - 1));
        end else begin : g_no_period
            assign auto_req_c = 1'b0;
        end
    endgenerate

    // Pending arithmetic: add this cycle's requests, retire an accepted ack,
    // saturate at MAX_PEND. Accept only happens in RAISE where pending >= 1.
    always_comb begin
        pend_sum_c   = SUM_W'(pending) + SUM_W'(req_i) + SUM_W'(auto_req_c)
                     - SUM_W'(accept_c);
        pend_over_c  = (pend_sum_c > SUM_W'(MAX_PEND));
        pending_next = pend_over_c ? 8'(MAX_PEND) : pend_sum_c[7:0];
    end

`ifdef EXT_INT_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
    logic [TCNT_W-1:0] tcnt;
    logic              tmo_hit_c;

    assign tmo_hit_c = (state == RAISE) && !accept_c
                       && (tcnt == TCNT_W'(TIMEOUT - 1));

    // RAISE dwell counter; cleared on every entry into RAISE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
        end else if ((state_next == RAISE) && (state != RAISE)) begin
            tcnt <= '0;
        end else if (state == RAISE) begin
            tcnt <= tcnt + TCNT_W'(1);
        end
    end

    // Sticky watchdog flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout <= 1'b0;
        end else if (tmo_hit_c) begin
            timeout <= 1'b1;
        end
    end
`endif

    // Next-state logic: IDLE waits for work, RAISE waits for ack, GAP
    // holds the line low for GAP_CYC cycles before re-evaluating.
    always_comb begin
        state_next  = state;
        gcnt_next   = gcnt;
        gap_enter_c = 1'b0;
        case (state)
            IDLE: begin
                if (pending != 8'd0) begin
                    state_next = RAISE;
                end
            end
            RAISE: begin
                if (accept_c) begin
                    gap_enter_c = 1'b1;
                end
`ifdef EXT_INT_TIMEOUT_EN
                if (tmo_hit_c) begin
                    gap_enter_c = 1'b1;
                end
`endif
                if (gap_enter_c) begin
                    state_next = GAP;
                    gcnt_next  = GCNT_W'(GAP_CYC - 1);
                end
            end
            GAP: begin
                if (gcnt == '0) begin
                    state_next = (pending_next != 8'd0) ? RAISE : IDLE;
                end else begin
                    gcnt_next = gcnt - GCNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                gcnt_next  = '0;
            end
        endcase
    end

    // State and gap counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            gcnt  <= '0;
        end else begin
            state <= state_next;
            gcnt  <= gcnt_next;
        end
    end

    // Interrupt line tracks the RAISE state with no extra cycle of delay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            interrupt <= 1'b0;
        end else begin
            interrupt <= (state_next == RAISE);
        end
    end

    // Request queue depth and overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= 8'd0;
            overflow <= 1'b0;
        end else begin
            pending <= pending_next;
            if (pend_over_c) begin
                overflow <= 1'b1;
            end
        end
    end

    // Accepted acknowledge counter and sticky spurious-ack flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_cnt  <= 16'd0;
            spurious <= 1'b0;
        end else begin
            if (accept_c) begin
                ack_cnt <= ack_cnt + 16'd1;
            end
            if (ack_c && (state != RAISE)) begin
                spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ext_int_responder.sv
// Testbench for ext_int_responder: directed scenarios plus randomized traffic
// against a cycle-level behavioural reference model. Two instances: one with
// no auto-request, one with a 16-cycle auto-request period.
module tb_ext_int_responder;

    localparam int          P0      = 0;
    localparam int          P1      = 16;
    localparam int          MAXP    = 7;
    localparam int          GAP     = 2;
    localparam logic [31:0] ACK     = 32'h0000_7f20;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic [3:0]  be0, be1;
    logic        irq0, irq1;
    logic [7:0]  pend0, pend1;
    logic [15:0] ackc0, ackc1;
    logic        ovf0, ovf1;
    logic        spur0, spur1;

    int checks = 0;
    int errors = 0;

    // Reference model state, one slot per instance.
    int m_pend [2];
    int m_ackc [2];
    int m_pcnt [2];
    int m_gap  [2];
    bit m_high [2];
    bit m_ovf  [2];
    bit m_spur [2];

    ext_int_responder #(.PERIOD(P0), .MAX_PEND(MAXP), .GAP_CYC(GAP), .ACK_ADDR(ACK)) dut0 (
        .clk(clk), .reset(reset), .req_i(req0), .m_int_addr(addr0), .m_int_byteen(be0),
        .interrupt(irq0), .pending(pend0), .ack_cnt(ackc0), .overflow(ovf0), .spurious(spur0)
    );

    ext_int_responder #(.PERIOD(P1), .MAX_PEND(MAXP), .GAP_CYC(GAP), .ACK_ADDR(ACK)) dut1 (
        .clk(clk), .reset(reset), .req_i(req1), .m_int_addr(addr1), .m_int_byteen(be1),
        .interrupt(irq1), .pending(pend1), .ack_cnt(ackc1), .overflow(ovf1), .spurious(spur1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 0; m_ackc[k] = 0; m_pcnt[k] = 0; m_gap[k] = 0;
            m_high[k] = 0; m_ovf[k] = 0; m_spur[k] = 0;
        end
    endfunction

    // One clock of behaviour from the rules: requests add, accepted acks
    // retire, a raised line waits for ack, a gap lasts GAP cycles.
    function automatic void model_step(input int k, input bit rq, input logic [31:0] ad,
                                       input logic [3:0] be, input int period);
        bit ack, acc, aut;
        int old, sum;
        ack = (be != 4'd0) && (ad == ACK);
        acc = ack && m_high[k];
        if (ack && !m_high[k]) m_spur[k] = 1;
        aut = 0;
        if (period > 0) begin
            aut = (m_pcnt[k] == period - 1);
            m_pcnt[k] = (m_pcnt[k] + 1) % period;
        end
        old = m_pend[k];
        sum = old + int'(rq) + int'(aut) - int'(acc);
        if (sum > MAXP) begin
            m_ovf[k] = 1;
            sum = MAXP;
        end
        if (acc) m_ackc[k] = (m_ackc[k] + 1) % 65536;
        if (m_high[k]) begin
            if (acc) begin
                m_high[k] = 0;
                m_gap[k]  = GAP;
            end
        end else if (m_gap[k] > 0) begin
            m_gap[k] = m_gap[k] - 1;
            if (m_gap[k] == 0) m_high[k] = (sum > 0);
        end else begin
            m_high[k] = (old > 0);
        end
        m_pend[k] = sum;
    endfunction

    // Advance one clock; inputs stay stable across the edge, outputs are
    // ready to sample on return (1 time unit after the edge).
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            model_step(0, req0, addr0, be0, P0);
            model_step(1, req1, addr1, be1, P1);
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({irq0, pend0, ackc0, ovf0, spur0} !== 27'd0) begin
            errors++;
            $display("FAIL reset_dut0: got irq=%b pend=%0d ackc=%0d ovf=%b spur=%b, want all 0",
                     irq0, pend0, ackc0, ovf0, spur0);
        end
        checks++;
        if ({irq1, pend1, ackc1, ovf1, spur1} !== 27'd0) begin
            errors++;
            $display("FAIL reset_dut1: got irq=%b pend=%0d ackc=%0d ovf=%b spur=%b, want all 0",
                     irq1, pend1, ackc1, ovf1, spur1);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_req();
        for (int i = 0; i < 4; i++) tick();
        req0 = 1'b1;
        tick();
        req0 = 1'b0;
        checks++;
        if (pend0 !== 8'd1 || irq0 !== 1'b0) begin
            errors++;
            $display("FAIL single_req_edge1: got pend=%0d irq=%b, want pend=1 irq=0", pend0, irq0);
        end
        tick();
        checks++;
        if (irq0 !== 1'b1) begin
            errors++;
            $display("FAIL single_req_rise: got irq=%b, want 1", irq0);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (irq0 !== 1'b1 || pend0 !== 8'd1) begin
            errors++;
            $display("FAIL single_req_hold: got irq=%b pend=%0d, want irq=1 pend=1", irq0, pend0);
        end
    endtask

    task automatic test_ack_one();
        addr0 = ACK; be0 = 4'b0001;
        tick();
        addr0 = '0; be0 = '0;
        checks++;
        if (irq0 !== 1'b0 || pend0 !== 8'd0 || ackc0 !== 16'd1) begin
            errors++;
            $display("FAIL ack_one: got irq=%b pend=%0d ackc=%0d, want irq=0 pend=0 ackc=1",
                     irq0, pend0, ackc0);
        end
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (irq0 !== 1'b0 || spur0 !== 1'b0) begin
            errors++;
            $display("FAIL ack_one_stay_low: got irq=%b spur=%b, want irq=0 spur=0", irq0, spur0);
        end
    endtask

    task automatic test_three_reqs();
        int acks = 0, phases = 0, low_run = 0;
        bit prev = 0;
        for (int i = 0; i < 40; i++) begin
            req0 = (i < 3);
            if (irq0 === 1'b1 && acks < 3) begin
                addr0 = ACK; be0 = 4'b0010; acks++;
            end else begin
                addr0 = '0; be0 = '0;
            end
            tick();
            if (irq0 === 1'b1 && !prev) begin
                phases++;
                if (phases > 1) begin
                    checks++;
                    if (low_run != GAP) begin
                        errors++;
                        $display("FAIL three_reqs_gap: got %0d low cycles, want %0d", low_run, GAP);
                    end
                end
            end
            if (irq0 === 1'b1) low_run = 0; else low_run++;
            prev = irq0;
        end
        req0 = 1'b0;
        checks++;
        if (phases != 3 || pend0 !== 8'd0 || ackc0 !== 16'd4 || irq0 !== 1'b0) begin
            errors++;
            $display("FAIL three_reqs_end: got phases=%0d pend=%0d ackc=%0d irq=%b, want 3 0 4 0",
                     phases, pend0, ackc0, irq0);
        end
    endtask

    task automatic test_overflow();
        req0 = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        req0 = 1'b0;
        checks++;
        if (pend0 !== 8'd7 || ovf0 !== 1'b1 || irq0 !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sat: got pend=%0d ovf=%b irq=%b, want 7 1 1", pend0, ovf0, irq0);
        end
        addr0 = 32'h0000_7f24; be0 = 4'b0001;
        tick();
        checks++;
        if (pend0 !== 8'd7 || ackc0 !== 16'd4 || irq0 !== 1'b1 || spur0 !== 1'b0) begin
            errors++;
            $display("FAIL wrong_addr: got pend=%0d ackc=%0d irq=%b spur=%b, want 7 4 1 0",
                     pend0, ackc0, irq0, spur0);
        end
        addr0 = ACK; be0 = 4'b0000;
        tick();
        checks++;
        if (pend0 !== 8'd7 || ackc0 !== 16'd4 || irq0 !== 1'b1 || spur0 !== 1'b0) begin
            errors++;
            $display("FAIL zero_byteen: got pend=%0d ackc=%0d irq=%b spur=%b, want 7 4 1 0",
                     pend0, ackc0, irq0, spur0);
        end
        for (int i = 0; i < 60; i++) begin
            if (irq0 === 1'b1) begin addr0 = ACK; be0 = 4'b1000; end
            else begin addr0 = '0; be0 = '0; end
            tick();
        end
        addr0 = '0; be0 = '0;
        checks++;
        if (pend0 !== 8'd0 || ackc0 !== 16'd11 || irq0 !== 1'b0) begin
            errors++;
            $display("FAIL overflow_drain: got pend=%0d ackc=%0d irq=%b, want 0 11 0", pend0, ackc0, irq0);
        end
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_period();
        int cd = 0, rises = 0, last = 0;
        bit prev = 0;
        reset_pulse();
        for (int i = 0; i < 88; i++) begin
            if (cd == 1) begin addr1 = ACK; be1 = 4'hF; end
            else begin addr1 = '0; be1 = '0; end
            if (cd > 0) cd--;
            tick();
            checks++;
            if (pend1 > 8'd1) begin
                errors++;
                $display("FAIL period_pending: cycle %0d got pend=%0d, want <=1", i, pend1);
            end
            if (irq1 === 1'b1 && !prev) begin
                rises++;
                if (rises > 1) begin
                    checks++;
                    if (i - last != P1) begin
                        errors++;
                        $display("FAIL period_interval: got %0d, want %0d", i - last, P1);
                    end
                end
                last = i;
                cd = 3;
            end
            prev = irq1;
        end
        addr1 = '0; be1 = '0;
        checks++;
        if (rises != 5 || ackc1 !== 16'd5 || ovf1 !== 1'b0 || spur1 !== 1'b0) begin
            errors++;
            $display("FAIL period_end: got rises=%0d ackc=%0d ovf=%b spur=%b, want 5 5 0 0",
                     rises, ackc1, ovf1, spur1);
        end
    endtask

    task automatic test_spurious();
        addr0 = ACK; be0 = 4'hF;
        tick();
        addr0 = '0; be0 = '0;
        tick();
        checks++;
        if (spur0 !== 1'b1 || pend0 !== 8'd0 || ackc0 !== 16'd0 || irq0 !== 1'b0) begin
            errors++;
            $display("FAIL spurious_idle: got spur=%b pend=%0d ackc=%0d irq=%b, want 1 0 0 0",
                     spur0, pend0, ackc0, irq0);
        end
    endtask

    task automatic test_async_reset();
        req0 = 1'b1;
        tick();
        req0 = 1'b0;
        tick();
        checks++;
        if (irq0 !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: got irq=%b, want 1", irq0);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({irq0, pend0, ackc0, ovf0, spur0} !== 27'd0) begin
            errors++;
            $display("FAIL async_reset: got irq=%b pend=%0d ackc=%0d ovf=%b spur=%b, want all 0",
                     irq0, pend0, ackc0, ovf0, spur0);
        end
        model_reset();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 600; i++) begin
            req0 = ($urandom_range(0, 3) == 0);
            req1 = ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 9);
            addr0 = '0; be0 = '0;
            if (r < 3) begin addr0 = ACK; be0 = 4'($urandom_range(1, 15)); end
            else if (r == 3) begin addr0 = 32'h0000_7f24; be0 = 4'b0001; end
            else if (r == 4) begin addr0 = ACK; be0 = 4'b0000; end
            r = $urandom_range(0, 9);
            addr1 = '0; be1 = '0;
            if (r < 3) begin addr1 = ACK; be1 = 4'($urandom_range(1, 15)); end
            else if (r == 3) begin addr1 = 32'h0000_7f24; be1 = 4'b0100; end
            tick();
            checks++;
            if (irq0 !== m_high[0] || pend0 !== 8'(m_pend[0]) || ackc0 !== 16'(m_ackc[0])
                || ovf0 !== m_ovf[0] || spur0 !== m_spur[0]) begin
                errors++;
                $display("FAIL random_dut0 cyc %0d: got irq=%b pend=%0d ackc=%0d ovf=%b spur=%b, want %b %0d %0d %b %b",
                         i, irq0, pend0, ackc0, ovf0, spur0,
                         m_high[0], m_pend[0], m_ackc[0], m_ovf[0], m_spur[0]);
            end
            checks++;
            if (irq1 !== m_high[1] || pend1 !== 8'(m_pend[1]) || ackc1 !== 16'(m_ackc[1])
                || ovf1 !== m_ovf[1] || spur1 !== m_spur[1]) begin
                errors++;
                $display("FAIL random_dut1 cyc %0d: got irq=%b pend=%0d ackc=%0d ovf=%b spur=%b, want %b %0d %0d %b %b",
                         i, irq1, pend1, ackc1, ovf1, spur1,
                         m_high[1], m_pend[1], m_ackc[1], m_ovf[1], m_spur[1]);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; be0 = '0; addr1 = '0; be1 = '0;
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; be0 = '0; addr1 = '0; be1 = '0;
        model_reset();
        test_reset();
        test_single_req();
        test_ack_one();
        test_three_reqs();
        test_overflow();
        test_period();
        test_spurious();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run can never hang.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
